// File: rtl/muxpga_pkg.sv
// muxpga_pkg: shared types and helpers for the mux-FPGA configuration loader.
package muxpga_pkg;
  localparam int CFG_BYTE_W = 8;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_SHIFT,
    ST_CHECK,
    ST_LATCH,
    ST_DONE,
    ST_ERR
  } cfg_state_t;
  function automatic int cfg_idx_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/muxpga_cfg_shifter.sv
// muxpga_cfg_shifter: parallel-load, MSB-first byte serializer with bit counter.
module muxpga_cfg_shifter
  import muxpga_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic [CFG_BYTE_W-1:0] byte_i,
  input  logic                  shift_en_i,
  output logic                  bit_out_o,
  output logic                  last_o
);
  localparam int CW = $clog2(CFG_BYTE_W);
  logic [CFG_BYTE_W-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // zeros shift in, so the register is empty once a byte has gone out
  always_comb begin
    sr_d  = clr_i ? '0 : load_i ? byte_i : shift_en_i ? {sr_q[CFG_BYTE_W-2:0], 1'b0} : sr_q;
    cnt_d = (clr_i || load_i) ? '0 : shift_en_i ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end
  assign bit_out_o = sr_q[CFG_BYTE_W-1];
  assign last_o    = (cnt_q == CW'(CFG_BYTE_W - 1));
endmodule

// File: rtl/muxpga_cfg_loader.sv
// muxpga_cfg_loader: receives a bitstream byte-wise, shifts it into the fabric
// config chain, verifies the trailing XOR checksum and commits with a latch pulse.
module muxpga_cfg_loader
  import muxpga_pkg::*;
#(
  parameter int CHAIN_LEN = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CFG_BYTE_W-1:0] byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  cfg_data,
  output logic                  cfg_shift,
  output logic                  cfg_latch,
  output logic                  fabric_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int NBYTES = CHAIN_LEN / 8;
  localparam int IW = cfg_idx_w(NBYTES);
  localparam logic [IW-1:0] NB_L = IW'(NBYTES);
  if (CHAIN_LEN < 8 || CHAIN_LEN % 8 != 0) begin : g_bad_len
    $error("CHAIN_LEN must be a multiple of 8 and at least 8");
  end
  cfg_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CFG_BYTE_W-1:0] csum_q, csum_d, rx_q, rx_d;
  logic [6:0] flags_q, flags_d;
  logic xfer, load, last;
  assign xfer = byte_ready & byte_valid;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    rx_d    = rx_q;
    load    = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      csum_d  = '0;
      rx_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: if (start) begin
          state_d = ST_RECV;
          idx_d   = '0;
          csum_d  = '0;
        end
        ST_RECV: if (xfer) begin
          if (idx_q == NB_L) begin
            rx_d    = byte_in;
            state_d = ST_CHECK;
          end else begin
            load    = 1'b1;
            csum_d  = csum_q ^ byte_in;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: if (last) begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_RECV;
        end
        ST_CHECK: state_d = (rx_q == csum_q) ? ST_LATCH : ST_ERR;
        ST_LATCH: state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end
  // outputs decoded from the next state so they switch on the same edge as the state
  always_comb begin
    flags_d = {state_d == ST_RECV, state_d == ST_SHIFT, state_d == ST_LATCH, state_d == ST_DONE,
               state_d inside {ST_RECV, ST_SHIFT, ST_CHECK, ST_LATCH},
               state_d == ST_DONE, state_d == ST_ERR};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      csum_q  <= '0;
      rx_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      rx_q    <= rx_d;
      flags_q <= flags_d;
    end
  end
  assign {byte_ready, cfg_shift, cfg_latch, fabric_en, busy, done, err} = flags_q;
  muxpga_cfg_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (abort),
    .load_i     (load),
    .byte_i     (byte_in),
    .shift_en_i (state_q == ST_SHIFT),
    .bit_out_o  (cfg_data),
    .last_o     (last)
  );
endmodule
